first_adder_core: RTL

//  Registered adder/accumulator stage that consumes operand wire-ins (ep 0x01, 0x02) and the

---
 rtl/first_pkg.sv | 23 ++
 rtl/first_add_unit.sv | 23 ++
 rtl/first_adder_core.sv | 118 +++++++++++
 3 files changed

// File: rtl/first_pkg.sv
// Shared types and constants for the First adder design: FSM state encoding,
// default widths and host-interface endpoint addresses.
package first_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ADD  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_LED_W = 8;

  localparam logic [7:0] EP_CTRL = 8'h00;
  localparam logic [7:0] EP_OP_A = 8'h01;
  localparam logic [7:0] EP_OP_B = 8'h02;
  localparam logic [7:0] EP_SUM  = 8'h21;
  localparam logic [7:0] EP_TRIG = 8'h40;
  localparam logic [7:0] EP_DONE = 8'h60;

endpackage

// File: rtl/first_add_unit.sv
// Combinational WIDTH+1 bit adder. Define FIRST_ADDER_SATURATE_EN to clamp the
// result to all ones on overflow; otherwise the sum wraps modulo 2^WIDTH.
module first_add_unit import first_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  logic [WIDTH:0] raw;

  assign raw     = {1'b0, a_i} + {1'b0, b_i};
  assign carry_o = raw[WIDTH];

`ifdef FIRST_ADDER_SATURATE_EN
  assign sum_o = raw[WIDTH] ? {WIDTH{1'b1}} : raw[WIDTH-1:0];
`else
  assign sum_o = raw[WIDTH-1:0];
`endif

endmodule

// File: rtl/first_adder_core.sv
// Registered adder/accumulator stage between the operand wire-ins and the result
// wire-out / done trigger-out. FIRST_ADDER_SATURATE_EN selects a clamping adder.
module first_adder_core import first_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int LED_W = DEF_LED_W
) (
  input  logic             ti_clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             auto_en_i,
  input  logic             accum_en_i,
  input  logic             start_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             missed_o,
  output logic [CNT_W-1:0] op_count_o,
  output logic [LED_W-1:0] led_o
);

  state_e           state_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic             missed_q;
  logic [CNT_W-1:0] op_count_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             acc_q;

  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] sum_d;
  logic             carry_d;
  logic             go;

  // Auto mode compares against the last loaded operands, not the last inputs.
  assign go    = start_i | (auto_en_i & ((op_a_i != a_q) | (op_b_i != b_q)));
  assign add_x = acc_q ? sum_q : a_q;

  first_add_unit #(.WIDTH(WIDTH)) u_add (
    .a_i     (add_x),
    .b_i     (b_q),
    .sum_o   (sum_d),
    .carry_o (carry_d)
  );

  always_ff @(posedge ti_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      missed_q   <= 1'b0;
      op_count_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= 1'b0;
    end else if (clear_i) begin
      state_q    <= ST_IDLE;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      missed_q   <= 1'b0;
      op_count_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i && state_q != ST_IDLE) begin
        missed_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (go) begin
            state_q <= ST_LOAD;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          a_q     <= op_a_i;
          b_q     <= op_b_i;
          acc_q   <= accum_en_i;
          state_q <= ST_ADD;
        end
        ST_ADD: begin
          sum_q   <= sum_d;
          carry_q <= carry_d;
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          op_count_q <= op_count_q + CNT_W'(1);
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Board LEDs are active-low.
  assign led_o      = ~sum_q[LED_W-1:0];
  assign sum_o      = sum_q;
  assign carry_o    = carry_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign missed_o   = missed_q;
  assign op_count_o = op_count_q;

endmodule
